// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm,
// one bit per clock, with busy/done handshake and overflow detection.
module bcd_double_dabble #(
  parameter int unsigned INPUT_WIDTH    = 7,
  parameter int unsigned DECIMAL_DIGITS = 3
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_Start,
  input  logic [INPUT_WIDTH-1:0]        i_Binary,
  output logic [4*DECIMAL_DIGITS-1:0]   o_BCD,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic                          o_Overflow
);

  // Decimal digits needed to represent the largest INPUT_WIDTH-bit value.
  function automatic int unsigned digits_needed(input int unsigned width);
    longint unsigned max_val;
    int unsigned     digits;
    max_val = (64'd1 << width) - 64'd1;
    digits  = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      digits++;
    end
    return digits;
  endfunction

  localparam int unsigned FullDigits    = digits_needed(INPUT_WIDTH);
  localparam int unsigned ScratchDigits = (FullDigits > DECIMAL_DIGITS) ? FullDigits
                                                                         : DECIMAL_DIGITS;
  localparam int unsigned ScratchWidth  = 4 * ScratchDigits;
  localparam int unsigned CntWidth      = $clog2(INPUT_WIDTH + 1);
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(INPUT_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                  state;
  logic [INPUT_WIDTH-1:0]  bin_sr;
  logic [ScratchWidth-1:0] scratch;
  logic [CntWidth-1:0]     bit_cnt;

  logic [ScratchWidth-1:0] scratch_adj;
  logic [ScratchWidth-1:0] scratch_next;
  logic [INPUT_WIDTH-1:0]  bin_next;
  logic                    overflow_next;

  always_comb begin
    scratch_adj = scratch;
    for (int unsigned k = 0; k < ScratchDigits; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
    {scratch_next, bin_next} = {scratch_adj, bin_sr} << 1;

    // Any nonzero digit above the reported ones means the value did not fit.
    overflow_next = 1'b0;
    for (int unsigned k = DECIMAL_DIGITS; k < ScratchDigits; k++) begin
      overflow_next = overflow_next | (scratch[4*k +: 4] != 4'd0);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= StIdle;
      bin_sr     <= '0;
      scratch    <= '0;
      bit_cnt    <= '0;
      o_BCD      <= '0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (i_Start) begin
            bin_sr  <= i_Binary;
            scratch <= '0;
            bit_cnt <= '0;
            o_Busy  <= 1'b1;
            state   <= StShift;
          end
        end
        StShift: begin
          scratch <= scratch_next;
          bin_sr  <= bin_next;
          bit_cnt <= bit_cnt + CntWidth'(1);
          if (bit_cnt == LastBit) begin
            state <= StDone;
          end
        end
        StDone: begin
          o_BCD      <= scratch[4*DECIMAL_DIGITS-1:0];
          o_Overflow <= overflow_next;
          o_Done     <= 1'b1;
          o_Busy     <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_double_dabble.sv
// Directed-vector bench for bcd_double_dabble: a default-size instance and a
// 10-bit/2-digit instance that exercises overflow.
module tb_bcd_double_dabble;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [6:0]  bin_a;
  logic [9:0]  bin_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_double_dabble dut_a (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Start    (start_a),
    .i_Binary   (bin_a),
    .o_BCD      (bcd_a),
    .o_Busy     (busy_a),
    .o_Done     (done_a),
    .o_Overflow (ovf_a)
  );

  bcd_double_dabble #(
    .INPUT_WIDTH    (10),
    .DECIMAL_DIGITS (2)
  ) dut_b (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Start    (start_b),
    .i_Binary   (bin_b),
    .o_BCD      (bcd_b),
    .o_Busy     (busy_b),
    .o_Done     (done_b),
    .o_Overflow (ovf_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at the negedge right after the accepting edge; edges counts that edge as 1.
  task automatic wait_done(input bit wide, input int budget, output int edges,
                           output int busy_cycles);
    edges       = 1;
    busy_cycles = 0;
    while (!(wide ? done_b : done_a) && edges <= budget) begin
      if (wide ? busy_b : busy_a) busy_cycles++;
      @(negedge clk);
      edges++;
    end
    if (edges > budget) check_eq("done_timeout", {31'd0, wide ? done_b : done_a}, 32'd1);
  endtask

  task automatic run_a(input logic [6:0] val, input logic [11:0] exp_bcd, input string tag);
    int edges, busy_cycles;
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = val;
    @(negedge clk);
    start_a = 1'b0;
    bin_a   = ~val;
    wait_done(1'b0, 20, edges, busy_cycles);
    check_eq({tag, "_bcd"}, {20'd0, bcd_a}, {20'd0, exp_bcd});
    check_eq({tag, "_ovf"}, {31'd0, ovf_a}, 32'd0);
    check_eq({tag, "_latency"}, edges, 32'd9);
    check_eq({tag, "_busy_cycles"}, busy_cycles, 32'd8);
    @(negedge clk);
    check_eq({tag, "_done_width"}, {31'd0, done_a}, 32'd0);
    check_eq({tag, "_bcd_hold"}, {20'd0, bcd_a}, {20'd0, exp_bcd});
  endtask

  task automatic run_b(input logic [9:0] val, input logic [7:0] exp_bcd, input logic exp_ovf,
                       input string tag);
    int edges, busy_cycles;
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = val;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, 25, edges, busy_cycles);
    check_eq({tag, "_bcd"}, {24'd0, bcd_b}, {24'd0, exp_bcd});
    check_eq({tag, "_ovf"}, {31'd0, ovf_b}, {31'd0, exp_ovf});
    check_eq({tag, "_latency"}, edges, 32'd12);
  endtask

  initial begin
    int n_done, first_done, edges, busy_cycles, gap;
    logic [11:0] seen_bcd;

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a   = '0;
    bin_b   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_bcd_a",  {20'd0, bcd_a}, 32'd0);
    check_eq("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done_a", {31'd0, done_a}, 32'd0);
    check_eq("rst_ovf_a",  {31'd0, ovf_a}, 32'd0);
    check_eq("rst_bcd_b",  {24'd0, bcd_b}, 32'd0);
    rst_n = 1'b1;

    run_a(7'd99,  12'h099, "v99");
    run_a(7'd0,   12'h000, "v0");
    run_a(7'd127, 12'h127, "v127");
    run_a(7'd1,   12'h001, "v1");
    run_a(7'd50,  12'h050, "v50");
    run_a(7'd109, 12'h109, "v109");

    // Second request while busy is ignored; input changes after acceptance are ignored.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 7'd45;
    @(negedge clk);
    start_a = 1'b0;
    bin_a   = 7'd77;
    @(negedge clk);
    start_a = 1'b1;
    n_done     = 0;
    first_done = 0;
    seen_bcd   = '0;
    for (int e = 3; e <= 20; e++) begin
      @(negedge clk);
      if (e == 4) start_a = 1'b0;
      if (done_a) begin
        n_done++;
        if (first_done == 0) begin
          first_done = e;
          seen_bcd   = bcd_a;
        end
      end
    end
    check_eq("ignore_ndone", n_done, 32'd1);
    check_eq("ignore_edge", first_done, 32'd9);
    check_eq("ignore_bcd", {20'd0, seen_bcd}, 32'h045);

    // Reset mid-SHIFT aborts the conversion.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 7'd12;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy_a}, 32'd0);
    check_eq("abort_bcd",  {20'd0, bcd_a}, 32'd0);
    check_eq("abort_done", {31'd0, done_a}, 32'd0);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    check_eq("abort_ndone", n_done, 32'd0);
    check_eq("abort_bcd_hold", {20'd0, bcd_a}, 32'd0);
    run_a(7'd88, 12'h088, "v88");

    // Back-to-back with start held high.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 7'd10;
    @(negedge clk);
    bin_a = 7'd11;
    wait_done(1'b0, 20, edges, busy_cycles);
    check_eq("b2b_first_latency", edges, 32'd9);
    check_eq("b2b_first_bcd", {20'd0, bcd_a}, 32'h010);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done_a && gap < 20);
    start_a = 1'b0;
    check_eq("b2b_gap", gap, 32'd9);
    check_eq("b2b_second_bcd", {20'd0, bcd_a}, 32'h011);

    // Wide instance: overflow detection.
    run_b(10'd1023, 8'h23, 1'b1, "w1023");
    run_b(10'd99,   8'h99, 1'b0, "w99");
    run_b(10'd100,  8'h00, 1'b1, "w100");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_double_dabble.md
BCD_DOUBLE_DABBLE -- requirements
Module: bcd_double_dabble

Interface
- REQ-001 SHALL have parameter INPUT_WIDTH, default 7: bit width of the unsigned binary input.
- REQ-002 SHALL have parameter DECIMAL_DIGITS, default 3: number of BCD digits produced.
- REQ-003 SHALL have port i_Clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-004 SHALL have port i_Rst_L, input, 1 bit: reset, synchronous and active-low.
- REQ-005 SHALL have port i_Start, input, 1 bit: request to convert i_Binary.
- REQ-006 SHALL have port i_Binary, input, INPUT_WIDTH bits: unsigned value to convert.
- REQ-007 SHALL have port o_BCD, output, 4*DECIMAL_DIGITS bits: last result; digit k occupies bits [4k+3:4k], with k=0 as the least significant digit.
- REQ-008 SHALL have port o_Busy, output, 1 bit: a conversion is in progress.
- REQ-009 SHALL have port o_Done, output, 1 bit: single-cycle pulse; o_BCD was updated this cycle.
- REQ-010 SHALL have port o_Overflow, output, 1 bit: the last converted value was >= 10^DECIMAL_DIGITS.

Function
- REQ-011 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
- REQ-012 IDLE with i_Start=1 at edge N SHALL:
  - capture i_Binary into a shift register;
  - clear the BCD scratch register and the bit counter;
  - enter SHIFT.
- REQ-013 IDLE with i_Start=0 SHALL hold all registers unchanged.
- REQ-014 Each edge in SHIFT SHALL perform one double-dabble iteration:
  - add 3 to every scratch digit whose value is >= 5;
  - shift {scratch, binary} left by 1 bit;
  - increment the bit counter.
- REQ-015 SHIFT SHALL last exactly INPUT_WIDTH edges (N+1 through N+INPUT_WIDTH), then enter DONE.
- REQ-016 The DONE edge (N+INPUT_WIDTH+1) SHALL:
  - load o_BCD from scratch;
  - load o_Overflow;
  - set o_Done=1 for exactly one cycle;
  - return to IDLE.
- REQ-017 Latency SHALL be INPUT_WIDTH+2 rising edges from the edge sampling i_Start to o_Done visible; this is 9 edges at the defaults.
- REQ-018 o_Busy SHALL be 1 exactly while the FSM is in SHIFT or DONE, and 0 in IDLE.
- REQ-019 i_Start SHALL be ignored while o_Busy=1; no queuing, and the in-flight conversion continues unaffected.
- REQ-020 i_Start=1 in the cycle o_Done=1 SHALL be accepted, since the FSM is already in IDLE; back-to-back throughput is one result per INPUT_WIDTH+2 cycles.
- REQ-021 i_Binary SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
- REQ-022 o_BCD and o_Overflow SHALL hold their values between o_Done pulses.
- REQ-023 If 10^DECIMAL_DIGITS <= 2^INPUT_WIDTH-1, the scratch register SHALL be sized to hold the full result:
  - o_BCD carries the low DECIMAL_DIGITS digits;
  - o_Overflow=1 when the captured value is >= 10^DECIMAL_DIGITS.
- REQ-024 At the defaults o_Overflow SHALL always be 0, since 127 < 1000.
- REQ-025 Each BCD digit of o_BCD SHALL be in the range 0-9 after every conversion.

Reset
- REQ-026 i_Rst_L=0 at an edge SHALL force:
  - FSM to IDLE;
  - o_BCD=0, o_Busy=0, o_Done=0, o_Overflow=0;
  - scratch and counter to 0.
- REQ-027 Reset SHALL take priority over i_Start and over any in-progress state, including mid-SHIFT and DONE.
- REQ-028 An aborted conversion SHALL produce no o_Done and SHALL leave o_BCD=0.
- REQ-029 The first i_Start sampled with i_Rst_L=1 after reset release SHALL be accepted normally.

Verification
- REQ-030 Defaults, i_Binary=99, 1-cycle i_Start -> o_Busy high for 8 cycles; o_Done at edge 9; o_BCD=0x099; o_Overflow=0.
- REQ-031 i_Binary=0 -> o_BCD=0x000; i_Binary=127 -> o_BCD=0x127; each o_Done exactly one cycle wide.
- REQ-032 Start 45, then raise i_Start with i_Binary=77 at edge 3 -> second request ignored; single o_Done; o_BCD=0x045.
- REQ-033 Start 12, assert i_Rst_L=0 at edge 4 -> no o_Done; o_BCD=0, o_Busy=0 after that edge; next start with 88 -> o_BCD=0x088.
- REQ-034 Back-to-back: i_Start held high continuously with i_Binary=10 then 11 -> o_Done pulses 9 cycles apart; o_BCD=0x010 then 0x011.
- REQ-035 INPUT_WIDTH=10, DECIMAL_DIGITS=2, i_Binary=1023 -> o_BCD=0x23, o_Overflow=1; i_Binary=99 -> o_BCD=0x99, o_Overflow=0.
